coproc0: RTL

COPROC0 -- requirements
Module: coproc0

---
 rtl/coproc0_pkg.sv | 20 ++
 rtl/coproc0_if.sv | 24 ++
 rtl/coproc0.sv | 61 ++++++
 3 files changed

// File: rtl/coproc0_pkg.sv
// coproc0_pkg: register numbers, field positions and exception codes for coprocessor 0.
package coproc0_pkg;
  localparam logic [4:0] REG_SR    = 5'd12;
  localparam logic [4:0] REG_CAUSE = 5'd13;
  localparam logic [4:0] REG_EPC   = 5'd14;
  localparam logic [4:0] REG_PRID  = 5'd15;
  localparam int SR_IE         = 0;
  localparam int SR_EXL        = 1;
  localparam int SR_IM_LO      = 10;
  localparam int CAUSE_CODE_LO = 2;
  localparam int CAUSE_IP_LO   = 10;
  localparam int CAUSE_BD      = 31;
  typedef enum logic [4:0] {
    EXC_INT  = 5'd0,
    EXC_ADEL = 5'd4,
    EXC_ADES = 5'd5,
    EXC_RI   = 5'd10,
    EXC_OV   = 5'd12
  } exc_code_e;
endpackage

// File: rtl/coproc0_if.sv
// coproc0_if: pipeline-to-CP0 signals; HWINT[0] carries the timer interrupt.
interface coproc0_if;
  logic [4:0]  RA;
  logic [4:0]  WA;
  logic        WE;
  logic [31:0] DIN;
  logic [31:0] PC;
  logic        BD_I;
  logic        EXC_REQ;
  logic [4:0]  EXC_CODE_I;
  logic        ERET;
  logic [5:0]  HWINT;
  logic [31:0] DOUT;
  logic [31:0] EPC_O;
  logic        EXC_TAKE;
  modport master (
    output RA, WA, WE, DIN, PC, BD_I, EXC_REQ, EXC_CODE_I, ERET, HWINT,
    input  DOUT, EPC_O, EXC_TAKE
  );
  modport slave (
    input  RA, WA, WE, DIN, PC, BD_I, EXC_REQ, EXC_CODE_I, ERET, HWINT,
    output DOUT, EPC_O, EXC_TAKE
  );
endinterface

// File: rtl/coproc0.sv
// coproc0: SR/CAUSE/EPC/PRID registers with exception/interrupt entry and eret.
module coproc0
  import coproc0_pkg::*;
#(
  parameter logic [31:0] PRID_VALUE = 32'h0000_2016
) (
  input logic       CLK_I,
  input logic       RST_I,
  coproc0_if.slave  bus
);
  logic [5:0]  im_q, im_d, ip_q, ip_d;
  logic        exl_q, exl_d, ie_q, ie_d, bd_q, bd_d;
  logic [4:0]  code_q, code_d;
  logic [29:0] epc_q, epc_d;
  logic [31:0] epc_take, sr, cause;
  logic        int_pend, take, wr_sr, wr_epc;
  logic        unused_pc;
  always_comb begin
    int_pend = |(bus.HWINT & im_q) & ie_q & ~exl_q;
    take     = int_pend | (bus.EXC_REQ & ~exl_q);
    // a flushed mtc0 must not commit
    wr_sr    = bus.WE & (bus.WA == REG_SR) & ~take;
    wr_epc   = bus.WE & (bus.WA == REG_EPC) & ~take;
    epc_take = bus.BD_I ? bus.PC - 32'd4 : bus.PC;
    im_d     = wr_sr ? bus.DIN[15:10] : im_q;
    ie_d     = wr_sr ? bus.DIN[0] : ie_q;
    exl_d    = take ? 1'b1 : bus.ERET ? 1'b0 : wr_sr ? bus.DIN[1] : exl_q;
    bd_d     = take ? bus.BD_I : bd_q;
    code_d   = take ? (int_pend ? 5'(EXC_INT) : bus.EXC_CODE_I) : code_q;
    epc_d    = take ? epc_take[31:2] : wr_epc ? bus.DIN[31:2] : epc_q;
    ip_d     = bus.HWINT;
  end
  always_ff @(posedge CLK_I) begin
    if (!RST_I) begin
      im_q   <= '1;
      ie_q   <= 1'b1;
      exl_q  <= 1'b0;
      bd_q   <= 1'b0;
      ip_q   <= '0;
      code_q <= '0;
      epc_q  <= '0;
    end else begin
      im_q   <= im_d;
      ie_q   <= ie_d;
      exl_q  <= exl_d;
      bd_q   <= bd_d;
      ip_q   <= ip_d;
      code_q <= code_d;
      epc_q  <= epc_d;
    end
  end
  assign sr           = {16'b0, im_q, 8'b0, exl_q, ie_q};
  assign cause        = {bd_q, 15'b0, ip_q, 3'b0, code_q, 2'b0};
  assign unused_pc    = ^epc_take[1:0];
  assign bus.EXC_TAKE = take;
  assign bus.EPC_O    = {epc_q, 2'b00};
  assign bus.DOUT     = bus.RA == REG_SR    ? sr :
                        bus.RA == REG_CAUSE ? cause :
                        bus.RA == REG_EPC   ? {epc_q, 2'b00} :
                        bus.RA == REG_PRID  ? PRID_VALUE : 32'h0;
endmodule
